// File: rtl/tone_player.sv
// Piezo tone player: plays one note command as a square wave for (len+1) beats, then goes silent.
// Define TONE_PLAYER_GAP_EN to insert a silent GAP_CYCLES articulation gap after every note.
module tone_player #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic       osc,
  input  logic       rst,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic [1:0] note_octave,
  input  logic [3:0] note_len,
  output logic       buzzer,
  output logic       busy
);

  localparam int unsigned HPW = $clog2(CLK_HZ / 2 + 2);
  localparam int unsigned BCW = $clog2(BEAT_CYCLES + 1);

`ifdef TONE_PLAYER_GAP_EN
  localparam int unsigned GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit          GAP_ON = (GAP_CYCLES != 0);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  function automatic int unsigned base_hz(input int unsigned code);
    case (code)
      1:       return 262;
      2:       return 277;
      3:       return 294;
      4:       return 311;
      5:       return 330;
      6:       return 349;
      7:       return 370;
      8:       return 392;
      9:       return 415;
      10:      return 440;
      11:      return 466;
      12:      return 494;
      default: return 0;
    endcase
  endfunction

  // Half-period for table index {code, octave}; rest codes get a harmless 1.
  function automatic int unsigned hp_calc(input int unsigned idx);
    int unsigned f;
    int unsigned h;
    f = base_hz(idx >> 2);
    if (f == 0) return 1;
    h = (CLK_HZ / (2 * f)) >> (idx % 4);
    return (h == 0) ? 1 : h;
  endfunction

  logic [HPW-1:0] hp_tab [64];
  for (genvar g = 0; g < 64; g++) begin : g_hp
    assign hp_tab[g] = HPW'(hp_calc(g));
  end

  state_t         state_q, state_n;
  logic [3:0]     code_q, code_n;
  logic [1:0]     oct_q, oct_n;
  logic [3:0]     len_q, len_n;
  logic [HPW-1:0] tone_q, tone_n;
  logic [BCW-1:0] bcyc_q, bcyc_n;
  logic [3:0]     beat_q, beat_n;
  logic           buzzer_n, ready_n, busy_n;
  logic [HPW-1:0] hp_sel;
  logic           is_rest;
`ifdef TONE_PLAYER_GAP_EN
  logic [GW-1:0]  gap_q, gap_n;
`endif

  assign hp_sel  = hp_tab[{code_q, oct_q}];
  assign is_rest = (code_q == 4'd0) || (code_q > 4'd12);

  // Next-state, counter and output decode
  always_comb begin
    state_n  = state_q;
    code_n   = code_q;
    oct_n    = oct_q;
    len_n    = len_q;
    tone_n   = tone_q;
    bcyc_n   = bcyc_q;
    beat_n   = beat_q;
    buzzer_n = buzzer;
`ifdef TONE_PLAYER_GAP_EN
    gap_n    = gap_q;
`endif
    case (state_q)
      IDLE: begin
        buzzer_n = 1'b0;
        if (note_valid && note_ready) begin
          state_n = PLAY;
          code_n  = note_code;
          oct_n   = note_octave;
          len_n   = note_len;
          tone_n  = '0;
          bcyc_n  = '0;
          beat_n  = '0;
        end
      end
      PLAY: begin
        if (!is_rest) begin
          if (tone_q == hp_sel - HPW'(1)) begin
            tone_n   = '0;
            buzzer_n = ~buzzer;
          end else begin
            tone_n = tone_q + HPW'(1);
          end
        end
        if (bcyc_q == BCW'(BEAT_CYCLES - 1)) begin
          bcyc_n = '0;
          if (beat_q == len_q) begin
            buzzer_n = 1'b0;
            state_n  = IDLE;
`ifdef TONE_PLAYER_GAP_EN
            if (GAP_ON) begin
              state_n = GAP;
              gap_n   = '0;
            end
`endif
          end else begin
            beat_n = beat_q + 4'd1;
          end
        end else begin
          bcyc_n = bcyc_q + BCW'(1);
        end
      end
`ifdef TONE_PLAYER_GAP_EN
      GAP: begin
        buzzer_n = 1'b0;
        if (gap_q == GW'(GAP_CYCLES - 1)) state_n = IDLE;
        else gap_n = gap_q + GW'(1);
      end
`endif
      default: begin
        state_n  = IDLE;
        buzzer_n = 1'b0;
      end
    endcase
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      oct_q      <= '0;
      len_q      <= '0;
      tone_q     <= '0;
      bcyc_q     <= '0;
      beat_q     <= '0;
      buzzer     <= 1'b0;
      note_ready <= 1'b0;
      busy       <= 1'b0;
`ifdef TONE_PLAYER_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_n;
      code_q     <= code_n;
      oct_q      <= oct_n;
      len_q      <= len_n;
      tone_q     <= tone_n;
      bcyc_q     <= bcyc_n;
      beat_q     <= beat_n;
      buzzer     <= buzzer_n;
      note_ready <= ready_n;
      busy       <= busy_n;
`ifdef TONE_PLAYER_GAP_EN
      gap_q      <= gap_n;
`endif
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: the driver queues expected note behaviour, a negedge monitor
// measures half-periods, busy length and inter-note idle time and compares against the queue.
`timescale 1ns/1ps
module tb_tone_player;

  localparam int unsigned CLK_HZ = 8800;
  localparam int unsigned BEAT   = 100;
  localparam int unsigned GAPC   = 4;
`ifdef TONE_PLAYER_GAP_EN
  localparam int EXP_GAP = int'(GAPC);
`else
  localparam int EXP_GAP = 0;
`endif

  logic       osc = 1'b0;
  logic       rst = 1'b0;
  logic       note_valid = 1'b0;
  logic [3:0] note_code = '0;
  logic [1:0] note_octave = '0;
  logic [3:0] note_len = '0;
  logic       note_ready;
  logic       buzzer;
  logic       busy;

  tone_player #(.CLK_HZ(CLK_HZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
    .osc(osc), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_code(note_code), .note_octave(note_octave), .note_len(note_len),
    .buzzer(buzzer), .busy(busy)
  );

  always #5 osc = ~osc;

  typedef struct {
    int hp;
    int play;
    int toggles;
    int idle_before;
    bit abort;
  } note_t;

  note_t note_q[$];
  string cn_q[$];
  int    ca_q[$];
  int    ce_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void compare(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endfunction

  task automatic push_chk(input string n, input int a, input int e);
    cn_q.push_back(n);
    ca_q.push_back(a);
    ce_q.push_back(e);
  endtask

  task automatic expect_note(input int hp, input int play, input int tog, input int idle_b,
                             input bit abort);
    note_t n;
    n = '{hp, play, tog, idle_b, abort};
    note_q.push_back(n);
  endtask

  // Present a command and return 1 ns after the edge that accepted it.
  task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [3:0] l);
    int w;
    w = 0;
    note_code = c;
    note_octave = o;
    note_len = l;
    note_valid = 1'b1;
    while (note_ready !== 1'b1 && w < 2000) begin
      @(negedge osc);
      w++;
    end
    if (w >= 2000) push_chk("accept_timeout", 0, 1);
    @(posedge osc);
    #1;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy !== 1'b0 || note_ready !== 1'b1) && w < 3000) begin
      @(negedge osc);
      w++;
    end
    if (w >= 3000) push_chk("idle_timeout", 0, 1);
    repeat (3) @(negedge osc);
  endtask

  // Monitor: drain immediate checks, then track the note currently on the buzzer.
  initial begin : monitor
    bit    active;
    bit    loud;
    note_t cur;
    int    cyc, last, tog, idle;
    logic  prev;
    string cn;
    int    ca, ce;
    active = 0; loud = 0; cyc = 0; last = 0; tog = 0; idle = 0; prev = 1'b0;
    forever begin
      @(negedge osc);
      while (cn_q.size() > 0) begin
        cn = cn_q.pop_front();
        ca = ca_q.pop_front();
        ce = ce_q.pop_front();
        compare(cn, ca, ce);
      end
      if (!active && busy === 1'b1) begin
        active = 1; cyc = 0; last = 1; tog = 0; loud = 0; prev = buzzer;
        if (note_q.size() == 0) begin
          compare("spurious_note", 1, 0);
          cur = '{0, 0, 0, -1, 1'b1};
        end else begin
          cur = note_q.pop_front();
          if (cur.idle_before >= 0) compare("idle_gap", idle, cur.idle_before);
          compare("ready_while_busy", int'(note_ready), 0);
        end
      end
      if (active) begin
        if (busy === 1'b1) begin
          cyc++;
          if (buzzer !== prev && cyc <= cur.play) begin
            if (cur.hp == 0) loud = 1;
            else begin
              compare("half_period", cyc - last, cur.hp);
              last = cyc;
              tog++;
            end
          end
          if (cyc > cur.play && buzzer !== 1'b0) loud = 1;
          prev = buzzer;
        end else begin
          active = 0;
          idle = 1;
          if (!cur.abort) begin
            compare("busy_len", cyc, cur.play + EXP_GAP);
            compare("toggles", tog, cur.toggles);
            compare("ready_after", int'(note_ready), 1);
          end
          compare("silent_rest_gap", int'(loud), 0);
          compare("buzzer_idle", int'(buzzer), 0);
        end
      end else if (busy !== 1'b1) begin
        idle++;
      end
    end
  end

  initial begin : stim
    // Reset and idle behaviour
    #1 rst = 1'b1;
    #1;
    push_chk("rst_buzzer", int'(buzzer), 0);
    push_chk("rst_ready", int'(note_ready), 0);
    push_chk("rst_busy", int'(busy), 0);
    #10 rst = 1'b0;
    @(posedge osc); #1;
    push_chk("ready_after_rst", int'(note_ready), 1);
    @(posedge osc); #3;
    rst = 1'b1;
    #1;
    push_chk("pulse_ready", int'(note_ready), 0);
    push_chk("pulse_buzzer", int'(buzzer), 0);
    @(negedge osc); #1;
    rst = 1'b0;
    push_chk("ready_before_edge", int'(note_ready), 0);
    @(posedge osc); #1;
    push_chk("ready_one_edge", int'(note_ready), 1);

    // Single A4, len 0: half-period 10, nine toggles inside 100 cycles
    expect_note(10, 100, 9, -1, 1'b0);
    send(4'd10, 2'd0, 4'd0);
    note_valid = 1'b0;
    wait_idle();

    // Octave and pitch: A octave 1 (HP 5), C octave 0 (HP 16)
    expect_note(5, 100, 19, -1, 1'b0);
    send(4'd10, 2'd1, 4'd0);
    note_valid = 1'b0;
    wait_idle();
    expect_note(16, 100, 6, -1, 1'b0);
    send(4'd1, 2'd0, 4'd0);
    note_valid = 1'b0;
    wait_idle();

    // Small half-periods: E octave 3 (HP 1), B octave 2 len 1 (HP 2)
    expect_note(1, 100, 99, -1, 1'b0);
    send(4'd5, 2'd3, 4'd0);
    note_valid = 1'b0;
    wait_idle();
    expect_note(2, 200, 99, -1, 1'b0);
    send(4'd12, 2'd2, 4'd1);
    note_valid = 1'b0;
    wait_idle();

    // Rests with len 2
    expect_note(0, 300, 0, -1, 1'b0);
    send(4'd0, 2'd1, 4'd2);
    note_valid = 1'b0;
    wait_idle();
    expect_note(0, 300, 0, -1, 1'b0);
    send(4'd14, 2'd0, 4'd2);
    note_valid = 1'b0;
    wait_idle();

    // Back-to-back with note_valid held: A then D (HP 14), second on first IDLE cycle
    expect_note(10, 100, 9, -1, 1'b0);
    expect_note(14, 100, 7, 1, 1'b0);
    send(4'd10, 2'd0, 4'd0);
    send(4'd3, 2'd0, 4'd0);
    note_valid = 1'b0;
    wait_idle();

    // Reset mid-PLAY at cycle 37
    expect_note(10, 100, 3, -1, 1'b1);
    send(4'd10, 2'd0, 4'd0);
    note_valid = 1'b0;
    repeat (36) @(posedge osc);
    #3;
    push_chk("midplay_buzzer_high", int'(buzzer), 1);
    rst = 1'b1;
    #1;
    push_chk("abort_buzzer", int'(buzzer), 0);
    push_chk("abort_ready", int'(note_ready), 0);
    push_chk("abort_busy", int'(busy), 0);
    @(negedge osc); @(negedge osc); #2;
    rst = 1'b0;
    @(posedge osc); #1;
    push_chk("abort_ready_release", int'(note_ready), 1);
    push_chk("abort_busy_release", int'(busy), 0);
    repeat (200) @(negedge osc);

    push_chk("scoreboard_empty", note_q.size(), 0);
    repeat (3) @(negedge osc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
